// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: scalar word typedefs, the NOP encoding,
// the PC reset default and the IF -> IF/ID payload.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a misalign flag to fetch_data_t.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef logic [XLEN-1:0] u64;
  typedef logic [ILEN-1:0] u32;

  // addi x0, x0, 0
  localparam u32 NOP_INSTR = 32'h0000_0013;

  localparam u64          PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // Fields are all zero whenever valid is low.
  typedef struct packed {
    logic valid;
    u64   pc;
    u32   instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;
`endif
  } fetch_data_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
//   ireq_valid    : request valid; ireq_addr held stable until the response beat
//   ireq_addr     : request address
//   iresp_data_ok : response valid this cycle
//   iresp_data    : instruction word, valid with iresp_data_ok
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic ireq_valid;
  u64   ireq_addr;
  logic iresp_data_ok;
  u32   iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with reset > redirect > advance priority.
//   clk, reset : clock, synchronous active-high reset (loads PC_RESET)
//   redirectEn : load redirectPc
//   redirectPc : redirect target
//   advance    : step pc by PC_STEP (wraps modulo 2^64)
//   pc         : current program counter
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter u64          PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic redirectEn,
  input  u64   redirectPc,
  input  logic advance,
  output u64   pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (redirectEn) begin
      pc <= redirectPc;
    end else if (advance) begin
      pc <= pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the instruction bus handshake and presents one
// fetch_data_t per accepted instruction to the IF/ID register. Handles ID
// back-pressure (stall) and EX redirects, including redirects that land while
// a request is outstanding (the stale response is drained in DISCARD).
//   clk, reset     : clock, synchronous active-high reset
//   ibus           : instruction bus master port
//   stall          : ID cannot accept this cycle
//   redirect_valid : PC redirect from EX; redirect_pc is the target
//   dataF_nxt      : {valid, pc, instr} to IF/ID, combinational from the response
//   fetch_busy     : a bus request is outstanding
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned PC issues no bus request
// and emits a NOP flagged as misaligned instead.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter u64          PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        ibus,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  u64                   redirect_pc,
  output fetch_data_t          dataF_nxt,
  output logic                 fetch_busy
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state;
  u64     pc;
  u64     reqAddr;
  u32     holdInstr;
  logic   advance;
  logic   reqIssue;
  logic   respOk;
  u32     respInstr;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  logic holdMisalign;
  assign misaligned = (pc[1:0] != 2'b00);
`endif

  fetch_pc_reg #(
    .PC_RESET (PC_RESET),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .redirectEn (redirect_valid),
    .redirectPc (redirect_pc),
    .advance    (advance),
    .pc         (pc)
  );

  // Response seen by REQ; a misaligned PC is answered locally with a NOP.
  always_comb begin
    reqIssue  = (state == REQ);
    respOk    = ibus.iresp_data_ok;
    respInstr = ibus.iresp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (state == REQ && misaligned) begin
      reqIssue  = 1'b0;
      respOk    = 1'b1;
      respInstr = NOP_INSTR;
    end
`endif
  end

  // DISCARD keeps presenting the address of the request it is draining.
  assign ibus.ireq_valid = !reset && (reqIssue || state == DISCARD);
  assign ibus.ireq_addr  = (state == DISCARD) ? reqAddr : pc;
  assign fetch_busy      = ibus.ireq_valid;

  // PC steps only when an instruction is handed to ID without a redirect.
  assign advance = !redirect_valid && !stall &&
                   ((state == REQ && respOk) || state == HOLD);

  // Output to IF/ID; a redirect drops whatever would have been emitted.
  always_comb begin
    dataF_nxt = '0;
    if (!reset && !redirect_valid) begin
      if (state == REQ && respOk) begin
        dataF_nxt.valid    = 1'b1;
        dataF_nxt.pc       = pc;
        dataF_nxt.instr    = respInstr;
`ifdef FETCH_MISALIGN_CHECK_EN
        dataF_nxt.misalign = misaligned;
`endif
      end else if (state == HOLD) begin
        dataF_nxt.valid    = 1'b1;
        dataF_nxt.pc       = pc;
        dataF_nxt.instr    = holdInstr;
`ifdef FETCH_MISALIGN_CHECK_EN
        dataF_nxt.misalign = holdMisalign;
`endif
      end
    end
  end

  // Handshake FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= REQ;
      reqAddr   <= PC_RESET;
      holdInstr <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      holdMisalign <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (respOk) begin
            if (!redirect_valid && stall) begin
              state     <= HOLD;
              holdInstr <= respInstr;
`ifdef FETCH_MISALIGN_CHECK_EN
              holdMisalign <= misaligned;
`endif
            end
          end else if (redirect_valid) begin
            // Request still in flight: remember its address to drain it.
            state   <= DISCARD;
            reqAddr <= pc;
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            state <= REQ;
          end
        end
        DISCARD: begin
          if (ibus.iresp_data_ok) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
